vga_bus_arbiter: RTL and testbench

// - Owns the VGA chip's ISA-style bus (BALE, MEMR/MEMW, IOR/IOW, SA0/SA12, DG, WAIT).
// - Shares that bus between two requesters:
//   - port 0: the Amiga Zorro-side bridge.
//   - port 1: the auxiliary engine (palette/register loader).
// - Arbitrates each request, sequences the full bus cycle with programmable timing, and returns read data plus a one-cycle ack.

---
 rtl/vga_bus_arbiter_pkg.sv | 40 ++++
 rtl/vga_bus_arbiter_rr_arb2.sv | 35 +++
 rtl/vga_bus_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_vga_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_bus_arbiter_pkg.sv
// Shared definitions for the VGA bus arbiter: state encodings, default
// bus timing, the latched request record and strobe selection helper.
package vga_bus_arbiter_pkg;

  // Bus-cycle sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_CMD   = 3'd2;
  localparam logic [2:0] ST_XWAIT = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  // Default timing in mclk cycles
  localparam int DEF_T_SETUP = 1;
  localparam int DEF_T_CMD   = 3;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_WAIT_TO = 255;

  // Request fields of one requester, captured at grant
  typedef struct packed {
    logic        io;
    logic        rw;
    logic        sa0;
    logic        sa12;
    logic [15:0] wdata;
  } busReq_t;

  // Encoding is {io, rw} so the selection is a plain cast
  typedef enum logic [1:0] {
    STB_MEMW = 2'b00,
    STB_MEMR = 2'b01,
    STB_IOW  = 2'b10,
    STB_IOR  = 2'b11
  } strobeSel_t;

  function automatic strobeSel_t selectStrobe(input logic io, input logic rw);
    return strobeSel_t'({io, rw});
  endfunction

endpackage

// File: rtl/vga_bus_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational; the port that
// was served last is remembered so the other one wins a tie.
module vga_rr_arb2 (
  input  logic       mclk,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  logic r_last;

  // Pick a single winner; on a tie favour the port not served last
  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  // Remember the last served port; port 1 after reset so port 0 wins first
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (i_enable && (|o_grant)) begin
      r_last <= o_grant[1];
    end
  end

endmodule

// File: rtl/vga_bus_arbiter.sv
// Owns the VGA chip's ISA-style bus and shares it between the Zorro bridge
// (port 0) and the auxiliary loader (port 1). Each granted request runs a
// full BALE/strobe cycle with programmable setup, command and hold times.
module vga_bus_arbiter
  import vga_bus_arbiter_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_CMD   = DEF_T_CMD,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int WAIT_TO = DEF_WAIT_TO
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        i_req0,
  input  logic        i_io0,
  input  logic        i_rw0,
  input  logic        i_sa0_0,
  input  logic        i_sa12_0,
  input  logic [15:0] i_wdata0,
  output logic        o_ack0,
  output logic        o_err0,
  input  logic        i_req1,
  input  logic        i_io1,
  input  logic        i_rw1,
  input  logic        i_sa0_1,
  input  logic        i_sa12_1,
  input  logic [15:0] i_wdata1,
  output logic        o_ack1,
  output logic        o_err1,
  output logic [15:0] o_rdata,
  input  logic        i_wait,
  output logic        o_bale,
  output logic        o_memr,
  output logic        o_memw,
  output logic        o_ior,
  output logic        o_iow,
  output logic        o_sa0,
  output logic        o_sa12,
  output logic [15:0] o_dg_out,
  output logic        o_dg_oe,
  input  logic [15:0] i_dg_in,
  output logic        o_busy
);

  // Counter reload values; every phase counts down to zero
  localparam logic [7:0] SETUP_LOAD  = 8'(T_SETUP - 1);
  localparam logic [7:0] CMD_LOAD    = 8'(T_CMD - 1);
  localparam logic [7:0] WAITTO_LOAD = 8'(WAIT_TO - 1);
  localparam logic [7:0] HOLD_LOAD   = (T_HOLD > 1) ? 8'(T_HOLD - 2) : 8'd0;

  logic [2:0]  r_state;
  logic [7:0]  r_cnt;
  logic        r_port;
  logic        r_io;
  logic        r_rw;
  logic        r_bale;
  logic        r_memr;
  logic        r_memw;
  logic        r_ior;
  logic        r_iow;
  logic        r_sa0;
  logic        r_sa12;
  logic [15:0] r_dgOut;
  logic        r_dgOe;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [15:0] r_rdata;

  logic [1:0]  w_grant;
  logic        w_anyGrant;
  busReq_t     w_req0;
  busReq_t     w_req1;
  busReq_t     w_sel;
  strobeSel_t  w_strobe;
  logic        w_finish;
  logic        w_finishErr;

  assign w_req0     = '{io: i_io0, rw: i_rw0, sa0: i_sa0_0, sa12: i_sa12_0, wdata: i_wdata0};
  assign w_req1     = '{io: i_io1, rw: i_rw1, sa0: i_sa0_1, sa12: i_sa12_1, wdata: i_wdata1};
  assign w_sel      = w_grant[1] ? w_req1 : w_req0;
  assign w_anyGrant = |w_grant;
  assign w_strobe   = selectStrobe(r_io, r_rw);

  vga_rr_arb2 u_arb (
    .mclk     (mclk),
    .reset    (reset),
    .i_req    ({i_req1, i_req0}),
    .i_enable (r_state == ST_IDLE),
    .o_grant  (w_grant)
  );

  // Decide when the strobe phase ends and whether it ended by timeout
  always_comb begin
    w_finish    = 1'b0;
    w_finishErr = 1'b0;
    case (r_state)
      ST_CMD: begin
        if ((r_cnt == 8'd0) && (r_io || i_wait)) begin
          w_finish = 1'b1;
        end
      end
      ST_XWAIT: begin
        if (i_wait) begin
          w_finish = 1'b1;
        end else if (r_cnt == 8'd0) begin
          w_finish    = 1'b1;
          w_finishErr = 1'b1;
        end
      end
      default: begin
        w_finish    = 1'b0;
        w_finishErr = 1'b0;
      end
    endcase
  end

  // Bus-cycle sequencer: grant, address, strobe, wait extension, end, hold
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_port  <= 1'b0;
      r_io    <= 1'b0;
      r_rw    <= 1'b0;
      r_bale  <= 1'b1;
      r_memr  <= 1'b1;
      r_memw  <= 1'b1;
      r_ior   <= 1'b1;
      r_iow   <= 1'b1;
      r_sa0   <= 1'b1;
      r_sa12  <= 1'b1;
      r_dgOut <= 16'h0000;
      r_dgOe  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_err0  <= 1'b0;
      r_err1  <= 1'b0;
      r_rdata <= 16'hFFFF;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyGrant) begin
            r_port <= w_grant[1];
            r_io   <= w_sel.io;
            r_rw   <= w_sel.rw;
            r_sa0  <= w_sel.sa0;
            r_sa12 <= w_sel.sa12;
            r_bale <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            if (!w_sel.rw) begin
              r_dgOe  <= 1'b1;
              r_dgOut <= w_sel.wdata;
            end
            r_cnt   <= SETUP_LOAD;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (r_cnt == 8'd0) begin
            case (w_strobe)
              STB_MEMW: r_memw <= 1'b0;
              STB_MEMR: r_memr <= 1'b0;
              STB_IOW:  r_iow  <= 1'b0;
              STB_IOR:  r_ior  <= 1'b0;
            endcase
            r_cnt   <= CMD_LOAD;
            r_state <= ST_CMD;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_CMD: begin
          if (r_cnt == 8'd0) begin
            if (w_finish) begin
              r_state <= ST_END;
            end else begin
              r_cnt   <= WAITTO_LOAD;
              r_state <= ST_XWAIT;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_XWAIT: begin
          if (w_finish) begin
            r_state <= ST_END;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_END: begin
          r_dgOe <= 1'b0;
          if (T_HOLD == 1) begin
            r_bale  <= 1'b1;
            r_sa0   <= 1'b1;
            r_sa12  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt   <= HOLD_LOAD;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == 8'd0) begin
            r_bale  <= 1'b1;
            r_sa0   <= 1'b1;
            r_sa12  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      if (w_finish) begin
        r_memr <= 1'b1;
        r_memw <= 1'b1;
        r_ior  <= 1'b1;
        r_iow  <= 1'b1;
        if (r_rw) begin
          r_rdata <= w_finishErr ? 16'hFFFF : i_dg_in;
        end
        if (r_port) begin
          r_ack1 <= 1'b1;
          r_err1 <= w_finishErr;
        end else begin
          r_ack0 <= 1'b1;
          r_err0 <= w_finishErr;
        end
      end
    end
  end

  assign o_bale   = r_bale;
  assign o_memr   = r_memr;
  assign o_memw   = r_memw;
  assign o_ior    = r_ior;
  assign o_iow    = r_iow;
  assign o_sa0    = r_sa0;
  assign o_sa12   = r_sa12;
  assign o_dg_out = r_dgOut;
  assign o_dg_oe  = r_dgOe;
  assign o_ack0   = r_ack0;
  assign o_ack1   = r_ack1;
  assign o_err0   = r_err0;
  assign o_err1   = r_err1;
  assign o_rdata  = r_rdata;
  assign o_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vga_bus_arbiter.sv
// Directed bench for vga_bus_arbiter: a default-timing instance plus one
// built with a short WAIT timeout, both fed from the same stimulus.
module tb_vga_bus_arbiter;

  logic        mclk = 1'b0;
  logic        reset;
  logic        i_req0, i_io0, i_rw0, i_sa0_0, i_sa12_0;
  logic [15:0] i_wdata0;
  logic        i_req1, i_io1, i_rw1, i_sa0_1, i_sa12_1;
  logic [15:0] i_wdata1;
  logic        i_wait;
  logic [15:0] i_dg_in;

  logic        o_ack0, o_err0, o_ack1, o_err1, o_bale, o_memr, o_memw, o_ior, o_iow;
  logic        o_sa0, o_sa12, o_dg_oe, o_busy;
  logic [15:0] o_rdata, o_dg_out;

  logic        t_ack0, t_err0, t_ack1, t_err1, t_bale, t_memr, t_memw, t_ior, t_iow;
  logic        t_sa0, t_sa12, t_dg_oe, t_busy;
  logic [15:0] t_rdata, t_dg_out;

  int nPass = 0;
  int nTotal = 0;

  always #5 mclk = ~mclk;

  vga_bus_arbiter dut (
    .mclk(mclk), .reset(reset),
    .i_req0(i_req0), .i_io0(i_io0), .i_rw0(i_rw0), .i_sa0_0(i_sa0_0), .i_sa12_0(i_sa12_0),
    .i_wdata0(i_wdata0), .o_ack0(o_ack0), .o_err0(o_err0),
    .i_req1(i_req1), .i_io1(i_io1), .i_rw1(i_rw1), .i_sa0_1(i_sa0_1), .i_sa12_1(i_sa12_1),
    .i_wdata1(i_wdata1), .o_ack1(o_ack1), .o_err1(o_err1),
    .o_rdata(o_rdata), .i_wait(i_wait), .o_bale(o_bale), .o_memr(o_memr), .o_memw(o_memw),
    .o_ior(o_ior), .o_iow(o_iow), .o_sa0(o_sa0), .o_sa12(o_sa12), .o_dg_out(o_dg_out),
    .o_dg_oe(o_dg_oe), .i_dg_in(i_dg_in), .o_busy(o_busy)
  );

  vga_bus_arbiter #(.WAIT_TO(4)) dutTo (
    .mclk(mclk), .reset(reset),
    .i_req0(i_req0), .i_io0(i_io0), .i_rw0(i_rw0), .i_sa0_0(i_sa0_0), .i_sa12_0(i_sa12_0),
    .i_wdata0(i_wdata0), .o_ack0(t_ack0), .o_err0(t_err0),
    .i_req1(i_req1), .i_io1(i_io1), .i_rw1(i_rw1), .i_sa0_1(i_sa0_1), .i_sa12_1(i_sa12_1),
    .i_wdata1(i_wdata1), .o_ack1(t_ack1), .o_err1(t_err1),
    .o_rdata(t_rdata), .i_wait(i_wait), .o_bale(t_bale), .o_memr(t_memr), .o_memw(t_memw),
    .o_ior(t_ior), .o_iow(t_iow), .o_sa0(t_sa0), .o_sa12(t_sa12), .o_dg_out(t_dg_out),
    .o_dg_oe(t_dg_oe), .i_dg_in(i_dg_in), .o_busy(t_busy)
  );

  // Advance one clock and settle just after the rising edge
  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    i_req0 = 0; i_io0 = 0; i_rw0 = 0; i_sa0_0 = 0; i_sa12_0 = 0; i_wdata0 = 16'h0;
    i_req1 = 0; i_io1 = 0; i_rw1 = 0; i_sa0_1 = 0; i_sa12_1 = 0; i_wdata1 = 16'h0;
    i_wait = 1'b1; i_dg_in = 16'h0000;
    #22;
    nTotal++;
    if ({o_bale, o_memr, o_memw, o_ior, o_iow, o_sa0, o_sa12} !== 7'h7F)
      $display("[TB] FAIL reset_bus_lines: got %b expected 1111111", {o_bale, o_memr, o_memw, o_ior, o_iow, o_sa0, o_sa12});
    else nPass++;
    nTotal++;
    if ({o_dg_oe, o_ack0, o_ack1, o_err0, o_err1, o_busy} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000", {o_dg_oe, o_ack0, o_ack1, o_err0, o_err1, o_busy});
    else nPass++;
    nTotal++;
    if (o_rdata !== 16'hFFFF || o_dg_out !== 16'h0000)
      $display("[TB] FAIL reset_data: rdata %h dg_out %h expected FFFF 0000", o_rdata, o_dg_out);
    else nPass++;
    reset = 1'b1;
    tick(); tick();
    nTotal++;
    if (o_busy !== 1'b0 || o_bale !== 1'b1)
      $display("[TB] FAIL reset_idle_after_release: busy %b bale %b expected 0 1", o_busy, o_bale);
    else nPass++;
  endtask

  task automatic test_mem_write;
    int memwLow = 0, memwStart = -1, ackEdge = -1, ackCount = 0, baleHigh = -1, oeOff = -1;
    logic dgBad = 0, otherBad = 0, baleBad = 0, oeAt0 = 0;
    logic [1:0] saAt0 = 2'b00;
    i_io0 = 0; i_rw0 = 0; i_sa0_0 = 0; i_sa12_0 = 1; i_wdata0 = 16'hA55A; i_wait = 1; i_req0 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 0) begin
        i_req0 = 0;
        saAt0 = {o_sa0, o_sa12};
        oeAt0 = o_dg_oe;
      end
      if (!o_memw) begin
        memwLow++;
        if (memwStart < 0) memwStart = k;
      end
      if (!o_memr || !o_ior || !o_iow) otherBad = 1;
      if (o_bale && !(o_memr && o_memw && o_ior && o_iow)) baleBad = 1;
      if (o_dg_oe && o_dg_out !== 16'hA55A) dgBad = 1;
      if (!o_dg_oe && oeOff < 0) oeOff = k;
      if (o_ack0) begin ackCount++; ackEdge = k; end
      if (o_bale && baleHigh < 0) baleHigh = k;
    end
    nTotal++;
    if (memwStart !== 1 || memwLow !== 3)
      $display("[TB] FAIL write_memw_window: start %0d len %0d expected 1 3", memwStart, memwLow);
    else nPass++;
    nTotal++;
    if (ackEdge !== 4 || ackCount !== 1)
      $display("[TB] FAIL write_ack: edge %0d count %0d expected 4 1", ackEdge, ackCount);
    else nPass++;
    nTotal++;
    if (baleHigh !== 6)
      $display("[TB] FAIL write_bale_rise: got %0d expected 6", baleHigh);
    else nPass++;
    nTotal++;
    if (oeAt0 !== 1'b1 || oeOff !== 5 || dgBad !== 1'b0)
      $display("[TB] FAIL write_dg: oe0 %b off %0d bad %b expected 1 5 0", oeAt0, oeOff, dgBad);
    else nPass++;
    nTotal++;
    if (saAt0 !== 2'b01 || {o_sa0, o_sa12} !== 2'b11)
      $display("[TB] FAIL write_sa: during %b after %b expected 01 11", saAt0, {o_sa0, o_sa12});
    else nPass++;
    nTotal++;
    if (otherBad !== 1'b0 || baleBad !== 1'b0)
      $display("[TB] FAIL write_strobe_exclusive: other %b bale %b expected 0 0", otherBad, baleBad);
    else nPass++;
  endtask

  task automatic test_io_read;
    int iorLow = 0, iorStart = -1, ackEdge = -1;
    logic [15:0] rdAtAck = 16'h0;
    logic errAtAck = 1'bx, ack0Seen = 0;
    i_io1 = 1; i_rw1 = 1; i_sa0_1 = 1; i_sa12_1 = 0; i_dg_in = 16'h1234; i_wait = 0; i_req1 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!o_ior) begin
        iorLow++;
        if (iorStart < 0) iorStart = k;
      end
      if (o_ack0) ack0Seen = 1;
      if (o_ack1) begin
        ackEdge = k; rdAtAck = o_rdata; errAtAck = o_err1; i_req1 = 0;
      end
    end
    nTotal++;
    if (iorStart !== 1 || iorLow !== 3)
      $display("[TB] FAIL ioread_ior_window: start %0d len %0d expected 1 3", iorStart, iorLow);
    else nPass++;
    nTotal++;
    if (ackEdge !== 4 || ack0Seen !== 1'b0)
      $display("[TB] FAIL ioread_ack1: edge %0d ack0 %b expected 4 0", ackEdge, ack0Seen);
    else nPass++;
    nTotal++;
    if (rdAtAck !== 16'h1234 || errAtAck !== 1'b0 || o_rdata !== 16'h1234)
      $display("[TB] FAIL ioread_data: rdata %h err %b held %h expected 1234 0 1234", rdAtAck, errAtAck, o_rdata);
    else nPass++;
  endtask

  task automatic test_back_to_back;
    int ackCount = 0, iowLow = 0;
    int order[4], edges[4];
    logic [15:0] dgAck[4];
    logic bothAck = 0;
    i_io0 = 1; i_rw0 = 0; i_wdata0 = 16'h1111; i_io1 = 1; i_rw1 = 0; i_wdata1 = 16'h2222;
    i_wait = 1; i_req0 = 1; i_req1 = 1;
    for (int k = 0; k < 34; k++) begin
      tick();
      if (!o_iow) iowLow++;
      if (o_ack0 && o_ack1) bothAck = 1;
      if (o_ack0 || o_ack1) begin
        if (ackCount < 4) begin
          order[ackCount] = o_ack1 ? 1 : 0;
          edges[ackCount] = k;
          dgAck[ackCount] = o_dg_out;
        end
        ackCount++;
        if (ackCount == 4) begin i_req0 = 0; i_req1 = 0; end
      end
    end
    nTotal++;
    if (ackCount !== 4 || iowLow !== 12 || bothAck !== 1'b0)
      $display("[TB] FAIL b2b_counts: acks %0d iow %0d both %b expected 4 12 0", ackCount, iowLow, bothAck);
    else nPass++;
    if (ackCount >= 4) begin
      nTotal++;
      if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1)
        $display("[TB] FAIL b2b_order: got %0d%0d%0d%0d expected 0101", order[0], order[1], order[2], order[3]);
      else nPass++;
      nTotal++;
      if (edges[0] !== 4 || edges[1] !== 11 || edges[2] !== 18 || edges[3] !== 25)
        $display("[TB] FAIL b2b_edges: got %0d %0d %0d %0d expected 4 11 18 25", edges[0], edges[1], edges[2], edges[3]);
      else nPass++;
      nTotal++;
      if (dgAck[0] !== 16'h1111 || dgAck[1] !== 16'h2222 || dgAck[2] !== 16'h1111 || dgAck[3] !== 16'h2222)
        $display("[TB] FAIL b2b_wdata: got %h %h %h %h expected 1111 2222 1111 2222", dgAck[0], dgAck[1], dgAck[2], dgAck[3]);
      else nPass++;
    end
  endtask

  task automatic test_wait_extend;
    int memrLow = 0, ackEdge = -1;
    logic [15:0] rdAtAck = 16'h0;
    logic errAtAck = 1'bx;
    i_io0 = 0; i_rw0 = 1; i_dg_in = 16'hBEEF; i_wait = 0; i_req0 = 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 0) i_req0 = 0;
      if (!o_memr) memrLow++;
      if (o_ack0) begin ackEdge = k; rdAtAck = o_rdata; errAtAck = o_err0; end
      if (k == 8) i_wait = 1;
    end
    nTotal++;
    if (memrLow !== 8 || ackEdge !== 9)
      $display("[TB] FAIL wait_extend_timing: memr %0d ack %0d expected 8 9", memrLow, ackEdge);
    else nPass++;
    nTotal++;
    if (rdAtAck !== 16'hBEEF || errAtAck !== 1'b0)
      $display("[TB] FAIL wait_extend_data: rdata %h err %b expected BEEF 0", rdAtAck, errAtAck);
    else nPass++;
  endtask

  task automatic test_wait_timeout;
    int memrLow = 0, ackEdge = -1, baleHigh = -1;
    logic [15:0] rdAtAck = 16'h0;
    logic errAtAck = 1'bx;
    i_io0 = 0; i_rw0 = 1; i_dg_in = 16'h1234; i_wait = 0; i_req0 = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) i_req0 = 0;
      if (!t_memr) memrLow++;
      if (t_ack0) begin ackEdge = k; rdAtAck = t_rdata; errAtAck = t_err0; end
      if (t_bale && baleHigh < 0) baleHigh = k;
    end
    nTotal++;
    if (memrLow !== 7 || ackEdge !== 8 || baleHigh !== 10)
      $display("[TB] FAIL timeout_timing: memr %0d ack %0d bale %0d expected 7 8 10", memrLow, ackEdge, baleHigh);
    else nPass++;
    nTotal++;
    if (rdAtAck !== 16'hFFFF || errAtAck !== 1'b1)
      $display("[TB] FAIL timeout_data: rdata %h err %b expected FFFF 1", rdAtAck, errAtAck);
    else nPass++;
    i_wait = 1;
    for (int k = 0; k < 4; k++) tick();
    nTotal++;
    if (o_busy !== 1'b0 || t_busy !== 1'b0 || t_err0 !== 1'b1)
      $display("[TB] FAIL timeout_settle: busy %b tbusy %b terr %b expected 0 0 1", o_busy, t_busy, t_err0);
    else nPass++;
  endtask

  task automatic test_reset_mid_cycle;
    int ackEdge = -1;
    logic [15:0] dgAt0 = 16'h0;
    logic ack1Seen = 0;
    i_io0 = 0; i_rw0 = 0; i_wdata0 = 16'hC3C3; i_wait = 1; i_req0 = 1;
    tick(); tick();
    nTotal++;
    if (o_memw !== 1'b0)
      $display("[TB] FAIL rst_mid_precondition: memw %b expected 0", o_memw);
    else nPass++;
    #2;
    reset = 1'b0;
    #1;
    nTotal++;
    if ({o_bale, o_memr, o_memw, o_ior, o_iow, o_dg_oe, o_busy} !== 7'b1111100)
      $display("[TB] FAIL rst_mid_async: got %b expected 1111100", {o_bale, o_memr, o_memw, o_ior, o_iow, o_dg_oe, o_busy});
    else nPass++;
    i_io1 = 1; i_rw1 = 0; i_wdata1 = 16'h5A5A; i_req1 = 1;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin dgAt0 = o_dg_out; i_req0 = 0; i_req1 = 0; end
      if (o_ack0) ackEdge = k;
      if (o_ack1) ack1Seen = 1;
    end
    nTotal++;
    if (dgAt0 !== 16'hC3C3 || ackEdge !== 4 || ack1Seen !== 1'b0)
      $display("[TB] FAIL rst_mid_first_grant: dg %h ack0 %0d ack1 %b expected C3C3 4 0", dgAt0, ackEdge, ack1Seen);
    else nPass++;
  endtask

  initial begin
    test_reset();
    test_mem_write();
    test_io_read();
    test_back_to_back();
    test_wait_extend();
    test_wait_timeout();
    test_reset_mid_cycle();
    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
